// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus bundle: instruction-memory port, decode port and redirect input.
// master = fetch controller, slave = memory/decode/next-PC environment.
interface fetch_ctrl_if;
  localparam int unsigned XLEN = 32;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            if_valid;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic            id_ready;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            addr_err;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc, addr_err,
    input  imem_ack, imem_rdata, id_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, addr_err,
    output imem_ack, imem_rdata, id_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, sequences the imem request/ack port,
// buffers fetched words in an output slot plus one-entry skid, and applies redirects.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_ctrl_if.master  bus
);
  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2,
    ST_HOLD    = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fetch_addr_q, fetch_addr_d;
  logic            imem_req_q, imem_req_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic            addr_err_q, addr_err_d;

  logic            slot_free_c;
  logic            misaligned_c;
  logic [XLEN-1:0] redir_pc_c;
  logic [XLEN-1:0] next_addr_c;

  assign slot_free_c  = !if_valid_q || bus.id_ready;
  assign misaligned_c = |bus.redirect_pc[1:0];
  assign redir_pc_c   = misaligned_c ? EXC_PC : bus.redirect_pc;
  assign next_addr_c  = fetch_addr_q + XLEN'(4);

  // Next-state: normal sequencing first, redirect overrides last.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    if_valid_d   = if_valid_q;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    addr_err_d   = 1'b0;

    // Decode took the current word; a load below re-asserts valid.
    if (if_valid_q && bus.id_ready) begin
      if_valid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        state_d      = ST_REQ;
        fetch_addr_d = pc_q;
      end
      ST_REQ: begin
        if (bus.imem_ack) begin
          pc_d         = next_addr_c;
          fetch_addr_d = next_addr_c;
          if (slot_free_c) begin
            if_valid_d = 1'b1;
            if_instr_d = bus.imem_rdata;
            if_pc_d    = fetch_addr_q;
          end else begin
            skid_valid_d = 1'b1;
            skid_instr_d = bus.imem_rdata;
            skid_pc_d    = fetch_addr_q;
            state_d      = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (bus.id_ready) begin
          if_valid_d   = skid_valid_q;
          if_instr_d   = skid_instr_q;
          if_pc_d      = skid_pc_q;
          skid_valid_d = 1'b0;
          state_d      = ST_REQ;
        end
      end
      ST_DISCARD: begin
        if (bus.imem_ack) begin
          fetch_addr_d = pc_q;
          state_d      = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.redirect) begin
      if_valid_d   = 1'b0;
      skid_valid_d = 1'b0;
      pc_d         = redir_pc_c;
      addr_err_d   = misaligned_c;
      // An unacked request must complete at its old address before the new one issues.
      if ((state_q == ST_REQ || state_q == ST_DISCARD) && !bus.imem_ack) begin
        state_d      = ST_DISCARD;
        fetch_addr_d = fetch_addr_q;
      end else begin
        state_d      = ST_REQ;
        fetch_addr_d = redir_pc_c;
      end
    end

    imem_req_d = (state_d == ST_REQ) || (state_d == ST_DISCARD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      fetch_addr_q <= RESET_PC;
      imem_req_q   <= 1'b0;
      if_valid_q   <= 1'b0;
      if_instr_q   <= '0;
      if_pc_q      <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      imem_req_q   <= imem_req_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      addr_err_q   <= addr_err_d;
    end
  end

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = fetch_addr_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_instr  = if_instr_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.addr_err  = addr_err_q;
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller that owns the architectural PC register and sequences the instruction-memory port. It issues one fetch per request/acknowledge handshake, delivers fetched words to decode through a one-deep output register plus a one-entry skid buffer, and applies redirects produced by the next-PC logic (taken branch, jump, register jump). It sits between the next-PC calculation and the IF/ID boundary.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC loaded on reset.
- EXC_PC, 32'h0000_4180, PC loaded when a misaligned redirect target is received.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address.
- imem_ack  in  1  memory has `imem_rdata` valid this cycle; may be asserted in the same cycle as `imem_req`.
- imem_rdata  in  32  fetched instruction word.
- if_valid  out  1  `if_instr` and `if_pc` hold a valid instruction.
- if_instr  out  32  instruction to decode.
- if_pc  out  32  address of `if_instr`.
- id_ready  in  1  decode consumes the current output this cycle.
- redirect  in  1  one-cycle pulse: replace the PC with `redirect_pc`.
- redirect_pc  in  32  redirect target.
- addr_err  out  1  one-cycle pulse: misaligned redirect target.

## Operation
- Registers:
  - `pc`: next address to fetch.
  - `fetch_addr`: drives `imem_addr`.
  - Output slot: `if_valid`, `if_instr`, `if_pc`.
  - Skid buffer: valid bit, instruction, PC.
  - `state`: IDLE, REQ, DISCARD, HOLD.
- Definition: `slot_free = !if_valid || id_ready`.
- Handshake rule:
  - Once `imem_req` is asserted, both `imem_req` and `imem_addr` stay stable until the cycle `imem_ack` is high.
  - `imem_ack` while `imem_req` is low is ignored.
- `imem_req` is 1 in REQ and DISCARD only.
- IDLE:
  - Next state is REQ.
  - `fetch_addr <= pc`.
- REQ, on `imem_ack` with `slot_free`:
  - Output slot <= {1, `imem_rdata`, `fetch_addr`}.
  - `pc` and `fetch_addr` <= `fetch_addr+4`.
  - Stay in REQ.
- REQ, on `imem_ack` with the slot not free:
  - Skid buffer <= {`imem_rdata`, `fetch_addr`}.
  - `pc` and `fetch_addr` <= `fetch_addr+4`.
  - Go to HOLD.
- REQ, no ack: hold all state.
- HOLD:
  - When `id_ready`: output slot <= skid contents, skid cleared, go to REQ.
  - Otherwise hold.
- In REQ and HOLD, when `id_ready` and no new data is loaded: `if_valid <= 0`.
- Redirect has top priority and overrides all of the above:
  - `if_valid <= 0`, skid cleared.
  - `pc <= redirect_pc`, or `EXC_PC` if `redirect_pc[1:0] != 0`; in the EXC_PC case `addr_err <= 1` for one cycle.
  - State REQ without ack in the same cycle: go to DISCARD; `fetch_addr` keeps the old address.
  - All other cases, including REQ with ack in the same cycle: go to REQ with `fetch_addr <=` new `pc`; returned data is dropped.
- DISCARD:
  - On `imem_ack`: drop the data, `fetch_addr <= pc`, go to REQ.
  - A further redirect while in DISCARD only updates `pc` (and `addr_err`); state stays DISCARD.
- Arithmetic: `pc+4` is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- The decode-side valid/ready contract: `if_valid` holds until `id_ready`; `if_instr` and `if_pc` are stable while `if_valid` is high and `id_ready` is low.

## Timing
- Reset values (asynchronous):
  - `state` = IDLE, `pc` = `fetch_addr` = RESET_PC.
  - `imem_addr` = RESET_PC.
  - `imem_req` = 0, `if_valid` = 0, skid valid = 0, `addr_err` = 0.
  - `if_instr` = 0, `if_pc` = 0.
- The first cycle after `rst_n` deasserts is IDLE; `imem_req` rises in the next cycle.
- Latency: ack at cycle n gives `if_valid` at n+1 and the next request address (+4) at n+1.
- Throughput: one instruction per cycle with same-cycle ack and continuous `id_ready`.
- Redirect at cycle n with no fetch in flight: `imem_addr = redirect_pc` and `if_valid = 0` at n+1.
- Redirect in flight: the new address is issued the cycle after the old request's ack.
- Reset asserted mid-transaction: all state is forced to reset values immediately; no pending ack is honoured.

## Test plan
- Reset, then ack every request with `imem_rdata = addr ^ 32'hA5A5_A5A5` and `id_ready = 1` → `if_pc` = 3000, 3004, 3008 on consecutive cycles; `if_instr` matches the pattern.
- `id_ready = 0` for 3 cycles while acks continue → skid fills, `imem_req` drops, no instruction is lost or duplicated; on `id_ready = 1` the stream resumes in order.
- Redirect to 32'h0000_3100 while the request at 300C is unacked and the ack arrives 2 cycles later → no instruction from 300C appears; the next request is 3100.
- Redirect to 32'h0000_3102 → `addr_err` pulses once; the next fetch is 4180.
- Redirect in the same cycle as an ack for 3008 → 3008 is dropped; the next `if_pc` is the redirect target.
- `pc` at FFFF_FFFC fetches → the next request is 0000_0000; `rst_n` pulsed low mid-request → `imem_req = 0`, `if_valid = 0`, and fetch restarts at 3000.
